uart_axis_cfg: RTL
==================

Name: uart_axis_cfg

Overview:
- Parametrised successor to the fixed 8-bit AXI-stream UART.
- Contains one AXI-stream slave for the transmit path and one AXI-stream master for the receive path.
- Data width, baud divider, parity mode and stop-bit count are set by parameter.
- Adds per-word error flags, an overrun pulse and an internal loopback mode, so the top-level loop test no longer needs an external tx-to-rx wire.

Parameters:
- DATA_WIDTH, 8, data bits per frame, legal 5..9.
- CLKS_PER_BIT, 868, aclk cycles per bit (100 MHz / 115200), legal >= 4.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted, legal 1 or 2.

Ports:
- aclk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- s_data_tdata  in  DATA_WIDTH  word to transmit.
- s_data_tvalid  in  1  tx word valid.
- s_data_tready  out  1  transmitter idle, can accept a word.
- m_data_tdata  out  DATA_WIDTH  received word.
- m_data_tvalid  out  1  received word valid.
- m_data_tready  in  1  downstream accepts the word.
- m_data_tuser  out  2  {frame_err, parity_err} for the current m_data word.
- overrun  out  1  one-cycle pulse when a received word is dropped.
- loopback  in  1  1 = rx path fed from internal tx, tx pin held high.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output.

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: tx=1, s_data_tready=1, m_data_tvalid=0, m_data_tdata=0, m_data_tuser=0, overrun=0.
- Reset puts both FSMs in IDLE, clears all counters and sets the rx synchroniser flops to 1.
- Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- TX transfer:
  - A word is accepted on the edge where s_data_tvalid and s_data_tready are both 1.
  - The word is latched and s_data_tready drops to 0 on that same edge.
  - tx goes low (start bit) on that edge, so latency is 0 cycles after acceptance.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Data is sent LSB first.
  - Parity bit: XOR of the data for even; its inverse for odd.
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - s_data_tready returns to 1 in the cycle after the last stop-bit cycle; no back-to-back acceptance inside a frame.
  - Frame length is (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- RX input path:
  - The rx source is loopback ? internal tx : rx pin.
  - It passes through a 2-flop synchroniser; this adds 2 cycles of latency on every sample.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: waits for a synchronised 0.
  - START: counts CLKS_PER_BIT/2 cycles (integer division), then samples. If the sample is 1, the start was a glitch and the FSM returns to IDLE with no output. If 0, it proceeds.
  - DATA and PARITY: one sample every CLKS_PER_BIT cycles (mid-bit); data is shifted in LSB first.
  - STOP: samples one stop bit only, regardless of STOP_BITS. A 0 sets frame_err.
  - Parity mismatch sets parity_err; parity_err is always 0 when PARITY=0.
  - After the stop-bit sample the FSM returns to IDLE immediately, so a new start bit can be detected half a bit early.
- RX output register:
  - On the stop-bit sample, if m_data_tvalid=0, or m_data_tvalid=1 and m_data_tready=1 in that same cycle, load tdata/tuser and set m_data_tvalid=1 on the next edge.
  - Otherwise drop the new word, keep the held word unchanged and pulse overrun for one cycle.
  - Words carrying errors are still delivered; the error flags travel in tuser.
  - m_data_tvalid stays 1, with tdata/tuser stable, until a handshake; it clears on the handshake edge unless reloaded in the same cycle.
- Loopback:
  - The source mux is combinational; the tx pin is forced to 1 while loopback=1.
  - Toggling loopback mid-frame may corrupt the in-flight RX frame. Corruption appears as error flags or a discarded glitch; neither FSM may hang.
- Arithmetic and widths:
  - Bit-timer width is $clog2(CLKS_PER_BIT); bit-index width is $clog2(DATA_WIDTH+1).
  - No timer may wrap; each timer reloads at CLKS_PER_BIT-1.

Test Plan:
- Reset and idle, CLKS_PER_BIT=4, DATA_WIDTH=8, PARITY=0, STOP_BITS=1:
  - Stimulus: hold arst=1 for 5 cycles.
  - Required: tx=1, s_data_tready=1, m_data_tvalid=0, overrun=0 throughout and after release.
- Loopback, same config, loopback=1:
  - Stimulus: send 8'h11, 8'h12, 8'h13 with m_data_tready=1.
  - Required: m_data_tdata = 11, 12, 13 with tuser=0; s_data_tready low for exactly 40 cycles per word; tx pin stays 1.
- Even parity with two stop bits, PARITY=2, STOP_BITS=2, external rx driven from tx:
  - Stimulus: send 8'hA5.
  - Required: tx sequence 0,1,0,1,0,0,1,0,1,0,1,1 with 4 cycles per bit; received 8'hA5 with tuser=2'b00.
- Parity error, PARITY=1:
  - Stimulus: bench drives a frame of 8'h01 with parity bit 1.
  - Required: tdata=8'h01, tuser=2'b01.
- Frame error:
  - Stimulus: bench drives 8'h3C with stop bit 0.
  - Required: tdata=8'h3C, tuser=2'b10; the next valid frame 8'h55 is received correctly.
- Overrun and glitch:
  - Stimulus: m_data_tready=0, two frames 8'h01 then 8'h02.
  - Required: m_data_tdata stays 8'h01 and overrun pulses once at the second stop-bit sample.
  - Stimulus: a 1-cycle low glitch on rx.
  - Required: no output and no error.

Source files
------------

// File: rtl/uart_axis_cfg.sv
// Parametrised AXI-stream UART with per-word error flags, overrun pulse and internal loopback.
// TX and RX are independent bit-timed FSMs; the RX source is muxed ahead of a 2-flop synchroniser.
module uart_axis_cfg #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] s_data_tdata,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  output logic [DATA_WIDTH-1:0] m_data_tdata,
  output logic                  m_data_tvalid,
  input  logic                  m_data_tready,
  output logic [1:0]            m_data_tuser,
  output logic                  overrun,
  input  logic                  loopback,
  input  logic                  rx,
  output logic                  tx
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] I_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e                tx_st_q;
  logic [TW-1:0]         tx_tmr_q;
  logic [IW-1:0]         tx_idx_q;
  logic [DATA_WIDTH-1:0] tx_sh_q;
  logic                  tx_par_q, tx_q, tready_q;

  // Start bit is driven on the accepting edge, so the frame begins with zero latency.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      tx_st_q  <= S_IDLE;
      tx_tmr_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
      tready_q <= 1'b1;
    end else begin
      case (tx_st_q)
        S_IDLE: if (s_data_tvalid && tready_q) begin
          tx_sh_q  <= s_data_tdata;
          tx_par_q <= (PARITY == 1) ? ~^s_data_tdata : ^s_data_tdata;
          tx_q     <= 1'b0;
          tready_q <= 1'b0;
          tx_tmr_q <= T_BIT;
          tx_st_q  <= S_START;
        end
        S_START: if (tx_tmr_q == '0) begin
          tx_tmr_q <= T_BIT;
          tx_idx_q <= '0;
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_st_q  <= S_DATA;
        end else tx_tmr_q <= tx_tmr_q - 1'b1;
        S_DATA: if (tx_tmr_q == '0) begin
          tx_tmr_q <= T_BIT;
          if (tx_idx_q == I_LAST) begin
            tx_idx_q <= '0;
            tx_q     <= (PARITY != 0) ? tx_par_q : 1'b1;
            tx_st_q  <= (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            tx_idx_q <= tx_idx_q + 1'b1;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end else tx_tmr_q <= tx_tmr_q - 1'b1;
        S_PAR: if (tx_tmr_q == '0) begin
          tx_tmr_q <= T_BIT;
          tx_q     <= 1'b1;
          tx_st_q  <= S_STOP;
        end else tx_tmr_q <= tx_tmr_q - 1'b1;
        S_STOP: if (tx_tmr_q == '0) begin
          if (tx_idx_q == I_STOP) begin
            tx_idx_q <= '0;
            tready_q <= 1'b1;
            tx_st_q  <= S_IDLE;
          end else begin
            tx_idx_q <= tx_idx_q + 1'b1;
            tx_tmr_q <= T_BIT;
          end
        end else tx_tmr_q <= tx_tmr_q - 1'b1;
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  assign tx            = loopback ? 1'b1 : tx_q;
  assign s_data_tready = tready_q;

  logic rx_src, sync1_q, sync2_q;
  assign rx_src = loopback ? tx_q : rx;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_src;
      sync2_q <= sync1_q;
    end
  end

  state_e                rx_st_q;
  logic [TW-1:0]         rx_tmr_q;
  logic [IW-1:0]         rx_idx_q;
  logic [DATA_WIDTH-1:0] rx_sh_q, m_tdata_q;
  logic [1:0]            m_tuser_q;
  logic                  rx_perr_q, m_tvalid_q, ovr_q;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rx_st_q    <= S_IDLE;
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (m_tvalid_q && m_data_tready) m_tvalid_q <= 1'b0;
      case (rx_st_q)
        S_IDLE: begin
          rx_perr_q <= 1'b0;
          if (!sync2_q) begin
            rx_tmr_q <= T_HALF;
            rx_st_q  <= S_START;
          end
        end
        S_START: if (rx_tmr_q == '0) begin
          rx_tmr_q <= T_BIT;
          rx_idx_q <= '0;
          rx_st_q  <= sync2_q ? S_IDLE : S_DATA;
        end else rx_tmr_q <= rx_tmr_q - 1'b1;
        S_DATA: if (rx_tmr_q == '0) begin
          rx_tmr_q <= T_BIT;
          rx_sh_q  <= {sync2_q, rx_sh_q[DATA_WIDTH-1:1]};
          if (rx_idx_q == I_LAST) rx_st_q <= (PARITY != 0) ? S_PAR : S_STOP;
          else rx_idx_q <= rx_idx_q + 1'b1;
        end else rx_tmr_q <= rx_tmr_q - 1'b1;
        S_PAR: if (rx_tmr_q == '0) begin
          rx_tmr_q  <= T_BIT;
          rx_perr_q <= sync2_q != ((PARITY == 1) ? ~^rx_sh_q : ^rx_sh_q);
          rx_st_q   <= S_STOP;
        end else rx_tmr_q <= rx_tmr_q - 1'b1;
        // Only the first stop bit is sampled; a held word blocks the new one.
        S_STOP: if (rx_tmr_q == '0) begin
          rx_st_q <= S_IDLE;
          if (!m_tvalid_q || m_data_tready) begin
            m_tdata_q  <= rx_sh_q;
            m_tuser_q  <= {~sync2_q, rx_perr_q};
            m_tvalid_q <= 1'b1;
          end else ovr_q <= 1'b1;
        end else rx_tmr_q <= rx_tmr_q - 1'b1;
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  assign m_data_tdata  = m_tdata_q;
  assign m_data_tuser  = m_tuser_q;
  assign m_data_tvalid = m_tvalid_q;
  assign overrun       = ovr_q;
endmodule
